intersection_phase_scheduler: RTL and testbench

//  Sequences a two-approach intersection (NS, EW) plus a pedestrian walk phase.
//  - Owns all dwell timing. No external TIMEOUT exists.
//  - Arbitrates green time between the two car-sensor requesters and a latched pedestrian request.
//  - Drives one GRN/YLW/RED triple per approach, plus WALK.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/phase_timer.sv | 21 ++
 rtl/intersection_phase_scheduler.sv | 150 +++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state encoding and approach constants for the intersection scheduler
package traffic_pkg;

  // Phase state; the two bits appear directly in PHASE[2:1]
  typedef enum logic [1:0] {
    S_GRN    = 2'd0,
    S_YLW    = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } phase_state_t;

  // Approach owning green/yellow
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating dwell counter, cleared on every phase change
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count up while enabled, hold at all-ones so long greens never wrap
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-approach signal sequencer with latched pedestrian walk phase
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int GRN_MIN     = 10,
  parameter int GRN_MAX     = 40,
  parameter int YLW_TIME    = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CAR_NS,
  input  logic       CAR_EW,
  input  logic       PED_REQ,
  output logic       NS_GRN,
  output logic       NS_YLW,
  output logic       NS_RED,
  output logic       EW_GRN,
  output logic       EW_YLW,
  output logic       EW_RED,
  output logic       WALK,
  output logic       PED_ACK,
  output logic [2:0] PHASE
);

  // Last-cycle thresholds of each dwell, sized to the timer
  localparam logic [CNT_W-1:0] GRN_MIN_LAST = CNT_W'(GRN_MIN - 1);
  localparam logic [CNT_W-1:0] GRN_MAX_LAST = CNT_W'(GRN_MAX - 1);
  localparam logic [CNT_W-1:0] YLW_LAST     = CNT_W'(YLW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST  = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_TIME - 1);

  phase_state_t     state, state_nxt;
  logic             dir, dir_nxt;
  logic             walk_done, walk_done_nxt;
  logic             ped_pending;
  logic [CNT_W-1:0] cnt;
  logic             own_car, opp_car, other_req;
  logic             phase_change;

  assign phase_change = (state_nxt != state);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (phase_change),
    .en    (1'b1),
    .cnt   (cnt)
  );

  // FSM state, green owner and walk-served flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_GRN;
      dir       <= DIR_NS;
      walk_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      walk_done <= walk_done_nxt;
    end
  end

  // Next-state logic: green yields only once a competing request exists
  always_comb begin
    state_nxt     = state;
    dir_nxt       = dir;
    walk_done_nxt = walk_done;
    own_car       = (dir == DIR_EW) ? CAR_EW : CAR_NS;
    opp_car       = (dir == DIR_EW) ? CAR_NS : CAR_EW;
    other_req     = opp_car | ped_pending;
    case (state)
      S_GRN: begin
        if ((cnt >= GRN_MIN_LAST) && other_req && (!own_car || (cnt >= GRN_MAX_LAST))) begin
          state_nxt = S_YLW;
        end
      end
      S_YLW: begin
        if (cnt == YLW_LAST) begin
          state_nxt = S_ALLRED;
        end
      end
      S_ALLRED: begin
        if (cnt == ALLRED_LAST) begin
          if (ped_pending && !walk_done) begin
            state_nxt = S_WALK;
          end else begin
            state_nxt     = S_GRN;
            dir_nxt       = ~dir;
            walk_done_nxt = 1'b0;
          end
        end
      end
      S_WALK: begin
        if (cnt == WALK_LAST) begin
          state_nxt     = S_ALLRED;
          walk_done_nxt = 1'b1;
        end
      end
      default: state_nxt = S_GRN;
    endcase
  end

  // Pedestrian latch: cleared as the walk starts, deaf during the walk itself
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ped_pending <= 1'b0;
    end else if ((state_nxt == S_WALK) && (state != S_WALK)) begin
      ped_pending <= 1'b0;
    end else if (PED_REQ && (state != S_WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  // Lamp decode: only the owning approach leaves red, and only in GRN/YLW
  always_comb begin
    NS_GRN = 1'b0;
    NS_YLW = 1'b0;
    NS_RED = 1'b1;
    EW_GRN = 1'b0;
    EW_YLW = 1'b0;
    EW_RED = 1'b1;
    WALK   = (state == S_WALK);
    if (state == S_GRN) begin
      if (dir == DIR_EW) begin
        EW_GRN = 1'b1;
        EW_RED = 1'b0;
      end else begin
        NS_GRN = 1'b1;
        NS_RED = 1'b0;
      end
    end else if (state == S_YLW) begin
      if (dir == DIR_EW) begin
        EW_YLW = 1'b1;
        EW_RED = 1'b0;
      end else begin
        NS_YLW = 1'b1;
        NS_RED = 1'b0;
      end
    end
  end

  assign PED_ACK = ped_pending;
  assign PHASE   = {state, dir};

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed vector bench for intersection_phase_scheduler
module tb_intersection_phase_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CAR_NS = 1'b0;
  logic       CAR_EW = 1'b0;
  logic       PED_REQ = 1'b0;
  logic       NS_GRN, NS_YLW, NS_RED, EW_GRN, EW_YLW, EW_RED, WALK, PED_ACK;
  logic [2:0] PHASE;

  int n_tests = 0;
  int n_fail  = 0;

  // Lamp patterns {NS_GRN,NS_YLW,NS_RED,EW_GRN,EW_YLW,EW_RED,WALK}
  localparam logic [6:0] L_NSG  = 7'b100_001_0;
  localparam logic [6:0] L_NSY  = 7'b010_001_0;
  localparam logic [6:0] L_EWG  = 7'b001_100_0;
  localparam logic [6:0] L_EWY  = 7'b001_010_0;
  localparam logic [6:0] L_RED  = 7'b001_001_0;
  localparam logic [6:0] L_WALK = 7'b001_001_1;

  // PHASE = {state, dir}
  localparam logic [2:0] P_GN = 3'b000;
  localparam logic [2:0] P_GE = 3'b001;
  localparam logic [2:0] P_YN = 3'b010;
  localparam logic [2:0] P_YE = 3'b011;
  localparam logic [2:0] P_RN = 3'b100;
  localparam logic [2:0] P_WN = 3'b110;

  intersection_phase_scheduler #(
    .CNT_W       (8),
    .GRN_MIN     (4),
    .GRN_MAX     (8),
    .YLW_TIME    (2),
    .ALLRED_TIME (1),
    .WALK_TIME   (3)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CAR_NS  (CAR_NS),
    .CAR_EW  (CAR_EW),
    .PED_REQ (PED_REQ),
    .NS_GRN  (NS_GRN),
    .NS_YLW  (NS_YLW),
    .NS_RED  (NS_RED),
    .EW_GRN  (EW_GRN),
    .EW_YLW  (EW_YLW),
    .EW_RED  (EW_RED),
    .WALK    (WALK),
    .PED_ACK (PED_ACK),
    .PHASE   (PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       chk;
    logic       ns;
    logic       ew;
    logic       ped;
    logic [6:0] lamps;
    logic       ack;
    logic [2:0] phase;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic chk, input logic ns, input logic ew,
                              input logic ped, input logic [6:0] lamps, input logic ack,
                              input logic [2:0] phase, input string name);
    vec_t v;
    v.rst = rst; v.chk = chk; v.ns = ns; v.ew = ew; v.ped = ped;
    v.lamps = lamps; v.ack = ack; v.phase = phase; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] el, input logic ea, input logic [2:0] ep);
    logic [10:0] act;
    logic [10:0] exp;
    act = {NS_GRN, NS_YLW, NS_RED, EW_GRN, EW_YLW, EW_RED, WALK, PED_ACK, PHASE};
    exp = {el, ea, ep};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lamps/ack/phase %b_%b_%b, expected %b_%b_%b",
               name, act[10:4], act[3], act[2:0], exp[10:4], exp[3], exp[2:0]);
    end
  endtask

  // Drive one cycle of inputs just after the edge, sample at the falling edge, advance
  task automatic drive(input logic rst, input logic ns, input logic ew, input logic ped);
    RESET = rst; CAR_NS = ns; CAR_EW = ew; PED_REQ = ped;
    @(negedge CLK);
  endtask

  task automatic advance;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    advance();
  endtask

  initial begin
    // Ped pulse at cycle 1, no cars
    tbl.push_back(mk(1, 0, 0, 0, 0, L_NSG, 0, P_GN, "rst_a"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_NSG, 0, P_GN, "ped_c0"));
    tbl.push_back(mk(0, 1, 0, 0, 1, L_NSG, 0, P_GN, "ped_c1"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_NSG, 1, P_GN, "ped_c2"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_NSG, 1, P_GN, "ped_c3"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_NSY, 1, P_YN, "ped_c4"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_NSY, 1, P_YN, "ped_c5"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_RED, 1, P_RN, "ped_c6"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_WALK, 0, P_WN, "ped_c7"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_WALK, 0, P_WN, "ped_c8"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_WALK, 0, P_WN, "ped_c9"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_RED, 0, P_RN, "ped_c10"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_EWG, 0, P_GE, "ped_c11"));
    tbl.push_back(mk(0, 1, 0, 0, 0, L_EWG, 0, P_GE, "ped_c12"));
    // Both cars held: max-green handover, then reset during EW yellow
    tbl.push_back(mk(1, 0, 0, 0, 0, L_NSG, 0, P_GN, "rst_b"));
    for (int c = 0; c <= 7; c++)
      tbl.push_back(mk(0, 1, 1, 1, 0, L_NSG, 0, P_GN, $sformatf("both_c%0d", c)));
    tbl.push_back(mk(0, 1, 1, 1, 0, L_NSY, 0, P_YN, "both_c8"));
    tbl.push_back(mk(0, 1, 1, 1, 0, L_NSY, 0, P_YN, "both_c9"));
    tbl.push_back(mk(0, 1, 1, 1, 0, L_RED, 0, P_RN, "both_c10"));
    for (int c = 11; c <= 18; c++)
      tbl.push_back(mk(0, 1, 1, 1, (c == 17) ? 1'b1 : 1'b0, L_EWG, (c == 18) ? 1'b1 : 1'b0, P_GE,
                       $sformatf("both_c%0d", c)));
    tbl.push_back(mk(1, 1, 1, 1, 0, L_EWY, 1, P_YE, "both_c19_rst"));
    tbl.push_back(mk(0, 1, 1, 1, 0, L_NSG, 0, P_GN, "after_rst"));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ns, tbl[i].ew, tbl[i].ped);
      if (tbl[i].chk) check(tbl[i].name, tbl[i].lamps, tbl[i].ack, tbl[i].phase);
      advance();
    end

    // Idle: green stays with NS forever
    do_reset();
    for (int c = 0; c < 50; c++) begin
      drive(0, 0, 0, 0);
      check($sformatf("idle_c%0d", c), L_NSG, 1'b0, P_GN);
      advance();
    end

    // EW car only: NS yields at minimum green
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      drive(0, 0, 1, 0);
      if (c <= 3)      check($sformatf("ew_c%0d", c), L_NSG, 1'b0, P_GN);
      else if (c <= 5) check($sformatf("ew_c%0d", c), L_NSY, 1'b0, P_YN);
      else if (c == 6) check("ew_c6", L_RED, 1'b0, P_RN);
      else             check($sformatf("ew_c%0d", c), L_EWG, 1'b0, P_GE);
      advance();
    end

    // Ped held through walk, released, then a fresh pulse during EW green
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      drive(0, 0, 0, ((c >= 1 && c <= 9) || c == 12) ? 1'b1 : 1'b0);
      if (c >= 2 && c <= 6)       check($sformatf("hold_c%0d", c), (c >= 4 && c <= 5) ? L_NSY : ((c == 6) ? L_RED : L_NSG),
                                        1'b1, (c >= 4 && c <= 5) ? P_YN : ((c == 6) ? P_RN : P_GN));
      else if (c >= 7 && c <= 9)  check($sformatf("hold_walk_c%0d", c), L_WALK, 1'b0, P_WN);
      else if (c == 10)           check("hold_c10", L_RED, 1'b0, P_RN);
      else if (c == 11 || c == 12) check($sformatf("hold_c%0d", c), L_EWG, 1'b0, P_GE);
      else if (c == 13 || c == 14) check($sformatf("relatch_c%0d", c), L_EWG, 1'b1, P_GE);
      else if (c == 15)           check("relatch_ylw", L_EWY, 1'b1, P_YE);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
